kan_train_sequencer: RTL

Cycle-level controller for the 4-layer integer KAN training engine. On a start pulse it steps the shared layer datapath through the fixed per-record schedule: forward evaluate/reduce for layers 0–3, then differences, deltas 3→0, then update. It does this for every training record of every epoch, then runs a forward-only validation pass. During validation it accumulates the absolute error internally and reports the scaled total with `done`. It sits between the board top level (start, LEDs) and the layer/function arrays, which it drives through stage strobes and record/epoch indices.

---
 rtl/kan_train_sequencer.sv | 167 ++++++++++++++++
 1 files changed

// File: rtl/kan_train_sequencer.sv
// Stage sequencer for the 4-layer integer KAN trainer: train epochs, then validate.
// Optional `KAN_SEQ_CYCLE_COUNT_EN adds an active-cycle counter on cycle_count.
module kan_train_sequencer #(
    parameter int N_T_RECORDS = 8192,
    parameter int N_V_RECORDS = 2048,
    parameter int N_EPOCHS    = 32,
    parameter int N_ERR_SHIFT = 11,
    parameter int REC_W       = 13,
    parameter int EP_W        = 6
) (
    input  logic               CLK100MHZ,
    input  logic               CPU_RESET,
    input  logic               start,
    input  logic               hold,
    input  logic signed [31:0] model_out,
    input  logic signed [31:0] target,
    output logic               busy,
    output logic               stage_valid,
    output logic [3:0]         stage,
    output logic               training,
    output logic [REC_W-1:0]   rec_idx,
    output logic [EP_W-1:0]    epoch_idx,
    output logic               epoch_done,
    output logic               done,
    output logic [31:0]        error,
    output logic [31:0]        cycle_count
);
    typedef enum logic [1:0] {S_IDLE, S_TRAIN, S_VAL, S_DONE} state_t;

    localparam logic [3:0] ST_RD3  = 4'd7;
    localparam logic [3:0] ST_UPD  = 4'd13;
    localparam logic [3:0] ST_VERR = 4'd14;
    localparam logic [REC_W-1:0] T_LAST = REC_W'(N_T_RECORDS - 1);
    localparam logic [REC_W-1:0] V_LAST = REC_W'(N_V_RECORDS - 1);
    localparam logic [EP_W-1:0] EP_LAST = EP_W'(N_EPOCHS - 1);

    state_t state, state_n;
    logic busy_n, sv_n, training_n, ep_done_n, done_n, rec_last;
    logic [3:0] stage_n;
    logic [REC_W-1:0] rec_n;
    logic [EP_W-1:0] ep_n;
    logic [31:0] error_n;
    logic [39:0] acc, acc_n, scaled;
    logic signed [32:0] diff;
    logic [32:0] mag;

    always_comb begin
        diff = {target[31], target} - {model_out[31], model_out};
        mag  = diff[32] ? 33'(-diff) : 33'(diff);
    end

    // A stage shown with stage_valid is consumed at the next edge; hold only
    // suppresses issuing the following one, which is re-issued afterwards.
    always_comb begin
        state_n    = state;
        busy_n     = busy;
        sv_n       = 1'b0;
        stage_n    = stage;
        training_n = training;
        rec_n      = rec_idx;
        ep_n       = epoch_idx;
        ep_done_n  = 1'b0;
        done_n     = 1'b0;
        error_n    = error;
        acc_n      = acc;
        rec_last   = 1'b0;
        scaled     = '0;
        unique case (state)
            S_IDLE: begin
                if (start) begin
                    state_n    = S_TRAIN;
                    busy_n     = 1'b1;
                    sv_n       = !hold;
                    stage_n    = '0;
                    training_n = 1'b1;
                    rec_n      = '0;
                    ep_n       = '0;
                    acc_n      = '0;
                    error_n    = '0;
                end
            end
            S_TRAIN, S_VAL: begin
                sv_n = !hold;
                if (stage_valid) begin
                    if (state == S_VAL && stage == ST_VERR)
                        acc_n = acc + {7'd0, mag};
                    if (state == S_TRAIN && stage != ST_UPD)
                        stage_n = stage + 4'd1;
                    else if (state == S_VAL && stage == ST_RD3)
                        stage_n = ST_VERR;
                    else if (state == S_VAL && stage != ST_VERR)
                        stage_n = stage + 4'd1;
                    else begin
                        stage_n  = '0;
                        rec_last = (rec_idx == (training ? T_LAST : V_LAST));
                        rec_n    = rec_last ? '0 : rec_idx + 1'b1;
                        if (rec_last && state == S_TRAIN) begin
                            ep_n      = epoch_idx + 1'b1;
                            ep_done_n = 1'b1;
                            if (epoch_idx == EP_LAST) begin
                                state_n    = S_VAL;
                                training_n = 1'b0;
                            end
                        end
                        if (rec_last && state == S_VAL) begin
                            state_n = S_DONE;
                            busy_n  = 1'b0;
                            sv_n    = 1'b0;
                            done_n  = 1'b1;
                            scaled  = acc_n >> N_ERR_SHIFT;
                            error_n = (|scaled[39:31]) ? 32'h7FFF_FFFF
                                                       : scaled[31:0];
                        end
                    end
                end
            end
            S_DONE: state_n = S_IDLE;
            default: state_n = S_IDLE;
        endcase
    end

    always_ff @(posedge CLK100MHZ or posedge CPU_RESET) begin
        if (CPU_RESET) begin
            state       <= S_IDLE;
            busy        <= 1'b0;
            stage_valid <= 1'b0;
            stage       <= '0;
            training    <= 1'b0;
            rec_idx     <= '0;
            epoch_idx   <= '0;
            epoch_done  <= 1'b0;
            done        <= 1'b0;
            error       <= '0;
            acc         <= '0;
        end else begin
            state       <= state_n;
            busy        <= busy_n;
            stage_valid <= sv_n;
            stage       <= stage_n;
            training    <= training_n;
            rec_idx     <= rec_n;
            epoch_idx   <= ep_n;
            epoch_done  <= ep_done_n;
            done        <= done_n;
            error       <= error_n;
            acc         <= acc_n;
        end
    end

`ifdef KAN_SEQ_CYCLE_COUNT_EN
    logic [31:0] count;

    always_ff @(posedge CLK100MHZ or posedge CPU_RESET) begin
        if (CPU_RESET)
            count <= '0;
        else if (state == S_IDLE && start)
            count <= '0;
        else if (stage_valid)
            count <= count + 32'd1;
    end

    assign cycle_count = count;
`else
    assign cycle_count = 32'd0;
`endif

endmodule
